// File: rtl/shake128_sponge.sv
// SHAKE128 sponge controller: absorbs 64-bit message words, applies the 0x1F/0x80 padding,
// sequences an external Keccak-f[1600] core and squeezes the rate lanes one word at a time.
module shake128_sponge #(
    parameter int RATE_LANES = 21
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [63:0]   in_data,
    input  logic          in_last,
    input  logic [3:0]    in_bytes,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [63:0]   out_data,
    input  logic          stop,
    output logic          busy,
    output logic          perm_rst,
    output logic          perm_enable,
    output logic [1599:0] perm_in,
    input  logic [1599:0] perm_state_out,
    input  logic          perm_valid
);

    typedef enum logic [2:0] {IDLE, ABSORB, PAD, PERM_LOAD, PERM_RUN, SQUEEZE} state_t;

    localparam logic [4:0] LAST_LANE = 5'(RATE_LANES - 1);
    localparam logic [4:0] PAD_WRAP  = 5'(RATE_LANES);

    state_t            r_state;
    state_t            r_ret;
    logic [24:0][63:0] r_s;
    logic [4:0]        r_cnt;
    logic [4:0]        r_pad_lane;
    logic [2:0]        r_pad_byte;

    logic [3:0]        w_nb;
    logic [63:0]       w_mask;
    logic [4:0]        w_pad_lane;
    logic [2:0]        w_pad_byte;
    logic [24:0][63:0] w_pad;

    assign perm_in  = r_s;
    assign out_data = r_s[r_cnt];

    always_comb begin
        w_nb   = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
        w_mask = '0;
        for (int i = 0; i < 8; i++)
            w_mask[8*i +: 8] = (4'(i) < w_nb) ? 8'hFF : 8'h00;
        // a full final word pushes the pad into the next lane, byte 0
        w_pad_lane = w_nb[3] ? r_cnt + 5'd1 : r_cnt;
        w_pad_byte = w_nb[2:0];
        w_pad = '0;
        w_pad[r_pad_lane][{r_pad_byte, 3'b000} +: 8] = 8'h1F;
        w_pad[LAST_LANE][63:56] = w_pad[LAST_LANE][63:56] ^ 8'h80;
    end

    // state change plus the registered outputs that belong to the new state
    task automatic go_state(input state_t s);
        r_state     <= s;
        in_ready    <= (s == ABSORB);
        out_valid   <= (s == SQUEEZE);
        busy        <= (s != IDLE);
        perm_rst    <= (s == IDLE) || (s == PERM_LOAD);
        perm_enable <= (s == PERM_RUN);
    endtask

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_ret       <= ABSORB;
            r_s         <= '0;
            r_cnt       <= '0;
            r_pad_lane  <= '0;
            r_pad_byte  <= '0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            perm_enable <= 1'b0;
            perm_rst    <= 1'b1;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_s   <= '0;
                    r_cnt <= '0;
                    go_state(ABSORB);
                end
                ABSORB: if (in_valid) begin
                    if (in_last) begin
                        r_s[r_cnt] <= r_s[r_cnt] ^ (in_data & w_mask);
                        if (w_pad_lane == PAD_WRAP) begin
                            r_pad_lane <= '0;
                            r_pad_byte <= '0;
                            r_cnt      <= '0;
                            r_ret      <= PAD;
                            go_state(PERM_LOAD);
                        end else begin
                            r_pad_lane <= w_pad_lane;
                            r_pad_byte <= w_pad_byte;
                            go_state(PAD);
                        end
                    end else begin
                        r_s[r_cnt] <= r_s[r_cnt] ^ in_data;
                        if (r_cnt == LAST_LANE) begin
                            r_cnt <= '0;
                            r_ret <= ABSORB;
                            go_state(PERM_LOAD);
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                end
                PAD: begin
                    r_s   <= r_s ^ w_pad;
                    r_cnt <= '0;
                    r_ret <= SQUEEZE;
                    go_state(PERM_LOAD);
                end
                PERM_LOAD: go_state(PERM_RUN);
                PERM_RUN: if (perm_valid) begin
                    r_s <= perm_state_out;
                    go_state(r_ret);
                end
                SQUEEZE: begin
                    // a handshake coinciding with stop still delivers its word
                    if (stop) begin
                        go_state(IDLE);
                    end else if (out_ready) begin
                        if (r_cnt == LAST_LANE) begin
                            r_cnt <= '0;
                            r_ret <= SQUEEZE;
                            go_state(PERM_LOAD);
                        end else begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                end
                default: go_state(IDLE);
            endcase
        end
    end

endmodule
